// File: rtl/ps2_host_tx_if.sv
// Request/status bundle between a command source and the PS/2 host transmitter.
interface ps2_host_tx_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       busy;
    logic       done;
    logic       ack_err;
    logic       timeout;

    modport master (
        output tx_data, tx_valid,
        input  tx_ready, busy, done, ack_err, timeout
    );

    modport slave (
        input  tx_data, tx_valid,
        output tx_ready, busy, done, ack_err, timeout
    );
endinterface

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device byte transmitter: inhibit, request-to-send, clock out
// start/data/parity/stop on device clock falling edges, then check the ACK.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 750000
) (
    input  logic         CLK,
    input  logic         RST,
    ps2_host_tx_if.slave host,
    input  logic         ps2_clk_in,
    input  logic         ps2_data_in,
    output logic         ps2_clk_oe,
    output logic         ps2_data_oe
);
    localparam int IW = $clog2(INHIBIT_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_INHIBIT, S_REQ, S_SHIFT, S_ACK, S_WAIT_IDLE
    } state_t;

    state_t        state, state_nxt;
    logic [1:0]    clk_sync, dat_sync;
    logic          clk_prev, clk_s, dat_s, fall;
    logic [8:0]    frame;
    logic [3:0]    idx;
    logic          drv, nak, run;
    logic [IW-1:0] inh_cnt;
    logic [TW-1:0] to_cnt;
    logic          inh_last, to_hit, counting, accept;
    logic          set_done, set_err, set_to;
    logic          done_q, err_q, to_q;

    assign clk_s    = clk_sync[1];
    assign dat_s    = dat_sync[1];
    assign fall     = clk_prev & ~clk_s;
    assign accept   = host.tx_valid & host.tx_ready;
    assign inh_last = (inh_cnt == IW'(INHIBIT_CYCLES - 1));
    assign to_hit   = (to_cnt == TW'(TIMEOUT_CYCLES - 1));
    assign counting = (state == S_REQ) || (state == S_SHIFT) ||
                      (state == S_ACK) || (state == S_WAIT_IDLE);

    // run keeps tx_ready low for the whole reset and one edge after it
    assign host.tx_ready = (state == S_IDLE) && run;
    assign host.busy     = (state != S_IDLE);
    assign host.done     = done_q;
    assign host.ack_err  = err_q;
    assign host.timeout  = to_q;

    always_comb begin
        state_nxt   = state;
        ps2_clk_oe  = 1'b0;
        ps2_data_oe = 1'b0;
        set_done    = 1'b0;
        set_err     = 1'b0;
        set_to      = 1'b0;
        case (state)
            S_IDLE:      if (accept) state_nxt = S_INHIBIT;
            S_INHIBIT: begin
                ps2_clk_oe = 1'b1;
                if (inh_last) begin
                    ps2_data_oe = 1'b1;
                    state_nxt   = S_REQ;
                end
            end
            S_REQ: begin
                ps2_data_oe = 1'b1;
                if (fall) state_nxt = S_SHIFT;
            end
            S_SHIFT: begin
                ps2_data_oe = drv;
                if (fall && idx == 4'd8) state_nxt = S_ACK;
            end
            S_ACK:       if (fall) state_nxt = S_WAIT_IDLE;
            S_WAIT_IDLE: if (clk_s && dat_s) begin
                set_done  = ~nak;
                set_err   = nak;
                state_nxt = S_IDLE;
            end
            default:     state_nxt = S_IDLE;
        endcase
        // A stalled device overrides any completion in the same cycle
        if (counting && to_hit && !fall) begin
            set_done  = 1'b0;
            set_err   = 1'b0;
            set_to    = 1'b1;
            state_nxt = S_IDLE;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state    <= S_IDLE;
            clk_sync <= 2'b11;
            dat_sync <= 2'b11;
            clk_prev <= 1'b1;
            frame    <= '0;
            idx      <= '0;
            drv      <= 1'b0;
            nak      <= 1'b0;
            run      <= 1'b0;
            inh_cnt  <= '0;
            to_cnt   <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            to_q     <= 1'b0;
        end else begin
            state    <= state_nxt;
            clk_sync <= {clk_sync[0], ps2_clk_in};
            dat_sync <= {dat_sync[0], ps2_data_in};
            clk_prev <= clk_s;
            run      <= 1'b1;
            done_q   <= set_done;
            err_q    <= set_err;
            to_q     <= set_to;
            inh_cnt  <= (state == S_INHIBIT) ? inh_cnt + 1'b1 : '0;
            to_cnt   <= (counting && !fall) ? to_cnt + 1'b1 : '0;
            if (accept) frame <= {~^host.tx_data, host.tx_data};
            // frame shifts out LSB first; the stop bit is the released line in ACK
            if (fall) begin
                case (state)
                    S_REQ: begin
                        drv   <= ~frame[0];
                        frame <= {1'b1, frame[8:1]};
                        idx   <= '0;
                    end
                    S_SHIFT: begin
                        idx <= idx + 1'b1;
                        if (idx != 4'd8) begin
                            drv   <= ~frame[0];
                            frame <= {1'b1, frame[8:1]};
                        end
                    end
                    S_ACK:   nak <= dat_s;
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with an open-collector PS/2 device model.
module tb_ps2_host_tx;
    localparam int INH = 50;
    localparam int TO  = 400;
    localparam int H   = 20;

    logic CLK = 1'b0;
    logic RST = 1'b0;
    logic dev_clk = 1'b1;
    logic dev_data = 1'b1;
    logic ps2_clk_oe, ps2_data_oe;
    wire  ps2_clk_pad  = dev_clk & ~ps2_clk_oe;
    wire  ps2_data_pad = dev_data & ~ps2_data_oe;

    ps2_host_tx_if bus();

    ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
        .CLK(CLK), .RST(RST), .host(bus),
        .ps2_clk_in(ps2_clk_pad), .ps2_data_in(ps2_data_pad),
        .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe)
    );

    always #5 CLK = ~CLK;

    int n_done = 0, n_err = 0, n_to = 0, n_low = 0, n_start = 0;
    always @(negedge CLK) begin
        if (bus.done)    n_done  <= n_done + 1;
        if (bus.ack_err) n_err   <= n_err + 1;
        if (bus.timeout) n_to    <= n_to + 1;
        if (ps2_clk_oe)  n_low   <= n_low + 1;
        if (ps2_clk_oe && ps2_data_oe) n_start <= n_start + 1;
    end

    int total = 0, bad = 0;
    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", nm, got, exp);
        end
    endtask

    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 4 * INH; i++) begin
            @(negedge CLK);
            if (!ps2_clk_oe && ps2_data_oe) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Device samples each bit at the end of clock-high, then pulls clock low.
    task automatic dev_run(input int nfalls, input bit ack, output logic [10:0] got);
        got = '0;
        for (int k = 0; k < nfalls; k++) begin
            repeat (H) @(negedge CLK);
            got[k] = ps2_data_pad;
            if (k == 10) dev_data = ~ack;
            @(negedge CLK);
            dev_clk = 1'b0;
            repeat (H) @(negedge CLK);
            dev_clk = 1'b1;
            if (k == 10) dev_data = 1'b1;
        end
    endtask

    typedef struct {
        logic [7:0]  d;
        bit          ack;
        logic [10:0] bits;
        bit          exp_done;
        bit          exp_err;
    } vec_t;
    vec_t vecs[5];

    task automatic run_vec(input vec_t v);
        int d0, e0, t0, l0, s0;
        bit ok;
        logic [10:0] got;
        d0 = n_done; e0 = n_err; t0 = n_to; l0 = n_low; s0 = n_start;
        @(negedge CLK); bus.tx_data = v.d; bus.tx_valid = 1'b1;
        @(negedge CLK); bus.tx_valid = 1'b0; bus.tx_data = ~v.d;
        chk("busy_after_accept", bus.busy, 1);
        wait_req(ok);
        chk("req_seen", ok, 1);
        dev_run(11, v.ack, got);
        repeat (10) @(negedge CLK);
        chk("frame_bits", got, v.bits);
        chk("inhibit_len", n_low - l0, INH);
        chk("start_on_last", n_start - s0, 1);
        chk("done_cnt", n_done - d0, v.exp_done);
        chk("err_cnt", n_err - e0, v.exp_err);
        chk("to_cnt", n_to - t0, 0);
        chk("idle_ready", {bus.busy, bus.tx_ready}, 2'b01);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1);
    end

    initial begin
        int d0, e0, t0, s0, cnt;
        bit ok;
        logic [10:0] got;
        bus.tx_data = 8'h00; bus.tx_valid = 1'b0;
        vecs[0] = '{8'hED, 1'b1, 11'h7DA, 1'b1, 1'b0};
        vecs[1] = '{8'h01, 1'b1, 11'h402, 1'b1, 1'b0};
        vecs[2] = '{8'hF4, 1'b0, 11'h5E8, 1'b0, 1'b1};
        vecs[3] = '{8'h00, 1'b1, 11'h600, 1'b1, 1'b0};
        vecs[4] = '{8'hFF, 1'b0, 11'h7FE, 1'b0, 1'b1};

        repeat (3) @(negedge CLK);
        chk("rst_ready", bus.tx_ready, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_oe", {ps2_clk_oe, ps2_data_oe}, 0);
        chk("rst_status", {bus.done, bus.ack_err, bus.timeout}, 0);
        RST = 1'b1;
        @(negedge CLK);
        chk("ready_after_rst", bus.tx_ready, 1);

        foreach (vecs[i]) run_vec(vecs[i]);

        // device never clocks: abort exactly TO cycles after REQ entry
        d0 = n_done; e0 = n_err; t0 = n_to;
        @(negedge CLK); bus.tx_data = 8'hA5; bus.tx_valid = 1'b1;
        @(negedge CLK); bus.tx_valid = 1'b0;
        wait_req(ok);
        chk("to_req_seen", ok, 1);
        cnt = 0;
        for (int i = 0; i < 2 * TO; i++) begin
            @(negedge CLK);
            cnt++;
            if (bus.timeout) break;
        end
        chk("to_latency", cnt, TO);
        chk("to_release", {ps2_clk_oe, ps2_data_oe}, 0);
        repeat (5) @(negedge CLK);
        chk("to_pulses", n_to - t0, 1);
        chk("to_no_done", (n_done - d0) + (n_err - e0), 0);
        chk("to_ready", bus.tx_ready, 1);

        // reset while bit 4 of 0xED (a 0, data pulled low) is on the line
        d0 = n_done; e0 = n_err; t0 = n_to;
        @(negedge CLK); bus.tx_data = 8'hED; bus.tx_valid = 1'b1;
        @(negedge CLK); bus.tx_valid = 1'b0;
        wait_req(ok);
        dev_run(5, 1'b1, got);
        repeat (3) @(negedge CLK);
        chk("b4_driven", {ps2_clk_oe, ps2_data_oe}, 2'b01);
        RST = 1'b0;
        @(negedge CLK);
        chk("mid_rst_release", {ps2_clk_oe, ps2_data_oe}, 0);
        chk("mid_rst_ready", bus.tx_ready, 0);
        repeat (2) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        chk("mid_rst_ready_back", bus.tx_ready, 1);
        repeat (10) @(negedge CLK);
        chk("mid_rst_no_pulse", (n_done - d0) + (n_err - e0) + (n_to - t0), 0);

        // tx_valid held with new data: second frame only after return to IDLE
        d0 = n_done; s0 = n_start;
        @(negedge CLK); bus.tx_data = 8'hED; bus.tx_valid = 1'b1;
        @(negedge CLK); bus.tx_data = 8'hF4;
        wait_req(ok);
        dev_run(11, 1'b1, got);
        chk("held_frame1", got, 11'h7DA);
        wait_req(ok);
        chk("held_req2", ok, 1);
        chk("held_done1", n_done - d0, 1);
        chk("held_starts", n_start - s0, 2);
        bus.tx_valid = 1'b0;
        dev_run(11, 1'b1, got);
        repeat (10) @(negedge CLK);
        chk("held_frame2", got, 11'h5E8);
        chk("held_done2", n_done - d0, 2);
        chk("held_idle", bus.busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
